// File: rtl/enemy_car_sprite_if.sv
// enemy_car_sprite_if: pixel/control bundle between the pipeline and one enemy-car layer
interface enemy_car_sprite_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_tick;
  logic       spawn;
  logic [9:0] spawn_x;
  logic [3:0] step;
  logic       hit;
  logic       on_obj;
  logic       r_obj;
  logic       g_obj;
  logic       b_obj;
  logic       active;
  logic       gone;
  modport master (output pixel_x, pixel_y, frame_tick, spawn, spawn_x, step, hit,
                  input on_obj, r_obj, g_obj, b_obj, active, gone);
  modport slave  (input pixel_x, pixel_y, frame_tick, spawn, spawn_x, step, hit,
                  output on_obj, r_obj, g_obj, b_obj, active, gone);
endinterface

// File: rtl/enemy_car_sprite.sv
// enemy_car_sprite: one enemy car's spawn/descend/explode life cycle and its registered pixel layer
module enemy_car_sprite #(
  parameter int       CAR_W          = 16,
  parameter int       CAR_H          = 32,
  parameter int       SCREEN_W       = 640,
  parameter int       SCREEN_H       = 480,
  parameter logic [2:0] COLOR        = 3'b001,
  parameter int       EXPLODE_FRAMES = 16
) (
  input logic clk,
  input logic reset,
  enemy_car_sprite_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, EXPLODE} state_t;
  localparam logic [9:0] X_MAX  = 10'(SCREEN_W - CAR_W);
  localparam logic [7:0] E_LAST = 8'(EXPLODE_FRAMES - 1);
  state_t      r_state, w_state;
  logic [9:0]  r_x, r_y, w_x, w_y, w_dx, w_dy;
  logic [7:0]  r_ecnt, w_ecnt;
  logic [10:0] w_sum;
  logic        w_gone, w_in_box, w_corner, w_on, r_on, r_gone;
  logic [2:0]  w_col, r_rgb;
  assign w_sum = {1'b0, r_y} + {7'b0, bus.step};
  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_ecnt  = r_ecnt;
    w_gone  = 1'b0;
    case (r_state)
      IDLE: if (bus.spawn) begin
        w_state = ACTIVE;
        w_x     = (bus.spawn_x > X_MAX) ? X_MAX : bus.spawn_x;
        w_y     = '0;
        w_ecnt  = '0;
      end
      ACTIVE: if (bus.hit) begin
        w_state = EXPLODE;
        w_ecnt  = '0;
      end else if (bus.frame_tick) begin
        if (w_sum >= 11'(SCREEN_H)) begin
          w_state = IDLE;
          w_gone  = 1'b1;
        end else w_y = w_sum[9:0];
      end
      EXPLODE: if (bus.frame_tick) begin
        w_state = (r_ecnt == E_LAST) ? IDLE : EXPLODE;
        w_gone  = (r_ecnt == E_LAST);
        w_ecnt  = (r_ecnt == E_LAST) ? 8'd0 : r_ecnt + 8'd1;
      end
      default: w_state = IDLE;
    endcase
  end
  // dx/dy wrap when the pixel is left of/above the car, hence the explicit >= guards
  assign w_dx     = bus.pixel_x - r_x;
  assign w_dy     = bus.pixel_y - r_y;
  assign w_in_box = (bus.pixel_x >= r_x) && (w_dx < 10'(CAR_W)) &&
                    (bus.pixel_y >= r_y) && (w_dy < 10'(CAR_H));
  assign w_corner = ((w_dx == 10'd0) || (w_dx == 10'(CAR_W - 1))) &&
                    ((w_dy == 10'd0) || (w_dy == 10'(CAR_H - 1)));
  assign w_on     = (r_state != IDLE) && w_in_box && !w_corner;
  assign w_col    = (r_state == EXPLODE && r_ecnt[1]) ? 3'b011 : COLOR;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_ecnt  <= '0;
      r_on    <= 1'b0;
      r_rgb   <= '0;
      r_gone  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_ecnt  <= w_ecnt;
      r_on    <= w_on;
      r_rgb   <= w_on ? w_col : 3'b000;
      r_gone  <= w_gone;
    end
  end
  assign bus.on_obj = r_on;
  assign bus.r_obj  = r_rgb[0];
  assign bus.g_obj  = r_rgb[1];
  assign bus.b_obj  = r_rgb[2];
  assign bus.active = (r_state != IDLE);
  assign bus.gone   = r_gone;
endmodule
